// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   REG_W           register-index width
//   fwd_e           ALU operand forwarding select encodings
//   mem_state_e     data-memory handshake FSM states
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// forward_sel: forwarding source select for one Execute-stage source register.
// Ports:
//   rs          in   source register index in Execute
//   rd_m        in   destination register of the Memory-stage instruction
//   reg_write_m in   Memory-stage register-write enable
//   rd_w        in   destination register of the Writeback-stage instruction
//   reg_write_w in   Writeback-stage register-write enable
//   sel         out  operand source (FWD_NONE / FWD_WB / FWD_MEM)
import hazard_pkg::*;

module forward_sel (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_w,
  output logic [1:0]       sel
);

  // Memory holds the younger result, so it wins when both stages match.
  // x0 is never forwarded: it always reads as zero.
  always_comb begin
    sel = FWD_NONE;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / forwarding control for the 5-stage RISC-V core,
// plus the req/ack handshake that freezes the pipeline during a data-memory access.
// Optional feature macro: HAZARD_PERF_EN (enables the stall/flush performance counters;
// when undefined the counter ports are tied to zero).
// Ports:
//   clk, reset                          core clock, synchronous active-high reset
//   Rs1D, Rs2D                          Decode source registers
//   Rs1E, Rs2E, RdE                     Execute source / destination registers
//   RdM, RdW, RegWriteM, RegWriteW      Memory / Writeback destinations and write enables
//   ResultSrcE0                         Execute instruction is a load
//   PCSrcE                              taken branch / jump resolved in Execute
//   MemAccessM, dmem_ack, dmem_req      data-memory access handshake
//   StallF/D/E/M, FlushD/E/W            pipeline register hold / clear controls
//   ForwardAE, ForwardBE                ALU operand forwarding selects
//   stall_cycles, flush_events          performance counters
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | no access outstanding; a new access may be issued this cycle
// ST_WAIT | access issued in an earlier cycle, waiting for dmem_ack
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [XLEN-1:0]  stall_cycles,
  output logic [XLEN-1:0]  flush_events
);

  mem_state_e state, state_next;
  logic       lw_stall;
  logic       mem_stall;
  logic       req_raw;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  forward_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  assign lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  // The stall is independent of FSM state: the Memory instruction simply
  // cannot retire until its ack arrives.
  assign mem_stall = MemAccessM && !dmem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_raw    = 1'b0;
    case (state)
      ST_RUN: begin
        req_raw = MemAccessM;
        if (MemAccessM && !dmem_ack) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        req_raw = 1'b1;
        if (dmem_ack) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Memory stall dominates: Execute is frozen, so a pending PCSrcE is still
  // present in the ack cycle and its flush is taken then.
  always_comb begin
    dmem_req  = req_raw;
    StallF    = lw_stall | mem_stall;
    StallD    = lw_stall | mem_stall;
    StallE    = mem_stall;
    StallM    = mem_stall;
    FlushD    = PCSrcE & !mem_stall;
    FlushE    = (lw_stall | PCSrcE) & !mem_stall;
    FlushW    = mem_stall;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    if (reset) begin
      dmem_req  = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = FWD_NONE;
      ForwardBE = FWD_NONE;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [XLEN-1:0] CNT_ONE = XLEN'(1);

  logic [XLEN-1:0] stall_cnt;
  logic [XLEN-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF) stall_cnt <= stall_cnt + CNT_ONE;
      if (FlushE) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_events = flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. Output bundle layout:
// {dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE}
module tb_hazard_ctrl;

  localparam int TB_XLEN = 4;
  localparam logic [11:0] RESET_OUTS = 12'b0_0000_111_00_00;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemAccessM, dmem_ack;
  logic dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [TB_XLEN-1:0] stall_cycles, flush_events;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(TB_XLEN)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  typedef struct {
    string       name;
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        rwm, rww, ld, pcs, mem, ack;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] outs();
    return {dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
            ForwardAE, ForwardBE};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
    MemAccessM = 0; dmem_ack = 0;
  endtask

  task automatic check_counters(input string name, input int n_stall, input int n_flush);
`ifdef HAZARD_PERF_EN
    check({name, "_stall_cnt"}, 64'(stall_cycles), 64'(n_stall % (1 << TB_XLEN)));
    check({name, "_flush_cnt"}, 64'(flush_events), 64'(n_flush % (1 << TB_XLEN)));
`else
    check({name, "_stall_cnt"}, 64'(stall_cycles), 64'(0));
    check({name, "_flush_cnt"}, 64'(flush_events), 64'(0));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  // Forwarding as stated in words: the youngest in-flight producer of the
  // register wins; x0 and non-writing instructions never produce a value.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic vec_t mk(input string n,
                              input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                              input logic rwm, rww, ld, pcs, mem, ack,
                              input logic [11:0] exp);
    vec_t v;
    v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww;
    v.ld = ld; v.pcs = pcs; v.mem = mem; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  initial begin
    bit in_flight;
    int n_stall, n_flush;
    logic [11:0] e;
    logic ms, lw;

    //                   rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld pcs mem ack  expected
    vecs.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b0_0000_000_00_00));
    vecs.push_back(mk("fwd_mem_pri",0, 0, 7, 0, 0, 7, 7, 1, 1, 0, 0, 0, 0, 12'b0_0000_000_10_00));
    vecs.push_back(mk("fwd_rs_x0",  0, 0, 0, 0, 0, 7, 7, 1, 1, 0, 0, 0, 0, 12'b0_0000_000_00_00));
    vecs.push_back(mk("fwd_all_x0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 12'b0_0000_000_00_00));
    vecs.push_back(mk("fwd_wb",     0, 0, 7, 7, 0, 7, 7, 0, 1, 0, 0, 0, 0, 12'b0_0000_000_01_01));
    vecs.push_back(mk("fwd_split",  0, 0, 3, 4, 0, 3, 4, 1, 1, 0, 0, 0, 0, 12'b0_0000_000_10_01));
    vecs.push_back(mk("fwd_miss",   0, 0, 5, 0, 0, 4, 5, 1, 0, 0, 0, 0, 0, 12'b0_0000_000_00_00));
    vecs.push_back(mk("lu_rs1",     5, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 12'b0_1100_010_00_00));
    vecs.push_back(mk("lu_rs2",     0, 5, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 12'b0_1100_010_00_00));
    vecs.push_back(mk("lu_rd_x0",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 12'b0_0000_000_00_00));
    vecs.push_back(mk("no_load",    5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 12'b0_0000_000_00_00));
    vecs.push_back(mk("branch",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12'b0_0000_110_00_00));
    vecs.push_back(mk("lu_branch",  5, 0, 0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 12'b0_1100_110_00_00));
    vecs.push_back(mk("mem_1cyc",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 12'b1_0000_000_00_00));
    vecs.push_back(mk("mem_lu_br",  5, 0, 0, 0, 5, 0, 0, 0, 0, 1, 1, 1, 1, 12'b1_1100_110_00_00));
    vecs.push_back(mk("ack_no_mem", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12'b0_0000_000_00_00));

    set_idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    RdM = 7; Rs1E = 7; RegWriteM = 1; MemAccessM = 1;
    #1 check("reset_outs", 64'(outs()), 64'(RESET_OUTS));
    @(negedge clk);
    reset = 0;
    set_idle();
    #1 check_counters("post_reset", 0, 0);

    // Table vectors: none leaves an access outstanding, so the FSM stays in RUN.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; ResultSrcE0 = vecs[i].ld;
      PCSrcE = vecs[i].pcs; MemAccessM = vecs[i].mem; dmem_ack = vecs[i].ack;
      #1 check(vecs[i].name, 64'(outs()), 64'(vecs[i].exp));
    end

    // Load-use: lw x5 in E, add x6,x5,x1 in D; one stall, then WB forwarding.
    do_reset();
    Rs1D = 5; Rs2D = 1; RdE = 5; ResultSrcE0 = 1;
    #1 check("lu_seq_stall", 64'(outs()), 64'(12'b0_1100_010_00_00));
    @(negedge clk);
    RdE = 0; ResultSrcE0 = 0; RdM = 5; RegWriteM = 1;
    #1 check("lu_seq_bubble", 64'(outs()), 64'(12'b0_0000_000_00_00));
    @(negedge clk);
    Rs1D = 0; Rs2D = 0; Rs1E = 5; Rs2E = 1; RdM = 0; RegWriteM = 0; RdW = 5; RegWriteW = 1;
    #1 check("lu_seq_fwd_wb", 64'(outs()), 64'(12'b0_0000_000_01_00));

    // Memory wait of 3 cycles with a branch pending, then back-to-back access.
    do_reset();
    MemAccessM = 1; PCSrcE = 1;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("mem_wait_c%0d", c), 64'(outs()), 64'(12'b1_1111_001_00_00));
      @(negedge clk);
    end
    dmem_ack = 1;
    #1 check("mem_ack_cycle", 64'(outs()), 64'(12'b1_0000_110_00_00));
    @(negedge clk);
    PCSrcE = 0;
    #1 check("mem_back2back", 64'(outs()), 64'(12'b1_0000_000_00_00));
    @(negedge clk);
    MemAccessM = 0; dmem_ack = 0;
    #1 check("mem_idle_run", 64'(outs()), 64'(12'b0_0000_000_00_00));

    // Reset while waiting, with an ack in the same cycle.
    do_reset();
    MemAccessM = 1;
    @(negedge clk);
    #1 check("rw_in_wait", 64'(outs()), 64'(12'b1_1111_001_00_00));
    @(negedge clk);
    reset = 1; dmem_ack = 1; RdM = 7; Rs1E = 7; RegWriteM = 1;
    #1 check("rw_reset_outs", 64'(outs()), 64'(RESET_OUTS));
    @(negedge clk);
    reset = 0; set_idle();
    #1 check("rw_back_in_run", 64'(outs()), 64'(12'b0_0000_000_00_00));
    check_counters("rw", 0, 0);

    // 17 load-use stall cycles wrap the 4-bit counters to 1.
    do_reset();
    Rs1D = 5; RdE = 5; ResultSrcE0 = 1;
    repeat (17) @(negedge clk);
    set_idle();
    #1 check_counters("wrap17", 17, 17);

    // Randomized run against the reference model.
    do_reset();
    in_flight = 0; n_stall = 0; n_flush = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 39) == 0);
      Rs1D        = 5'($urandom_range(0, 3));
      Rs2D        = 5'($urandom_range(0, 3));
      Rs1E        = 5'($urandom_range(0, 3));
      Rs2E        = 5'($urandom_range(0, 3));
      RdE         = 5'($urandom_range(0, 3));
      RdM         = 5'($urandom_range(0, 3));
      RdW         = 5'($urandom_range(0, 3));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      ResultSrcE0 = ($urandom_range(0, 3) == 0);
      PCSrcE      = ($urandom_range(0, 3) == 0);
      MemAccessM  = 1'($urandom_range(0, 1));
      dmem_ack    = ($urandom_range(0, 4) < 2);
      #1;
      ms = MemAccessM && !dmem_ack;
      lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      if (reset) e = RESET_OUTS;
      else e = {in_flight || MemAccessM, lw || ms, lw || ms, ms, ms,
                PCSrcE && !ms, (lw || PCSrcE) && !ms, ms, ref_fwd(Rs1E), ref_fwd(Rs2E)};
      check($sformatf("rand_%0d", i), 64'(outs()), 64'(e));
      check_counters($sformatf("rand_%0d", i), n_stall, n_flush);
      if (reset) begin
        in_flight = 0; n_stall = 0; n_flush = 0;
      end else begin
        if (lw || ms) n_stall++;
        if ((lw || PCSrcE) && !ms) n_flush++;
        in_flight = (in_flight || MemAccessM) && !dmem_ack;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
